// File: rtl/brom_bus_arbiter_pkg.sv
// Shared definitions for the boot-ROM bus arbiter.
// - state_e           : arbiter FSM states (IDLE=0, BUSY=1, DONE=2)
// - DEF_TIMEOUT_RDATA : read data returned when the watchdog forces a completion
package brom_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [31:0] DEF_TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/brom_bus_arbiter_rr.sv
// Combinational round-robin arbiter.
// Requests are rotated so that index `ptr` lands at bit 0. The lowest set bit
// of the rotated vector is then picked, and the result is rotated back into
// the original index space.
// Ports:
//   req        in  N      request vector
//   ptr        in  IW     highest-priority index this round
//   gnt_onehot out N      one-hot grant (all zero when no request)
//   gnt_idx    out IW     index of the granted requester
//   gnt_any    out 1      at least one request present
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_onehot,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_any
);

  logic [N-1:0]  req_rot;
  logic [N-1:0]  oh_rot;
  logic [IW-1:0] enc;
  logic          found;
  int            pos;

  always_comb begin
    req_rot    = '0;
    oh_rot     = '0;
    enc        = '0;
    found      = 1'b0;
    gnt_onehot = '0;
    pos        = 0;

    // Rotate so that requester `ptr` sits at bit 0.
    for (int i = 0; i < N; i++) begin
      pos = i + int'(ptr);
      if (pos >= N) pos = pos - N;
      req_rot[i] = req[IW'(pos)];
    end

    // The lowest set bit wins.
    for (int i = 0; i < N; i++) begin
      if (req_rot[i] && !found) begin
        enc       = IW'(i);
        oh_rot[i] = 1'b1;
        found     = 1'b1;
      end
    end

    // Rotate the one-hot grant back into requester order.
    for (int i = 0; i < N; i++) begin
      pos = i + int'(ptr);
      if (pos >= N) pos = pos - N;
      gnt_onehot[IW'(pos)] = oh_rot[i];
    end

    pos = int'(enc) + int'(ptr);
    if (pos >= N) pos = pos - N;
    gnt_idx = IW'(pos);
    gnt_any = found;
  end

endmodule

// File: rtl/brom_bus_arbiter.sv
// Shares the boot-ROM native-memory slave port among NUM_MASTERS requesters.
// Arbitration is round-robin, and only one transaction is outstanding at a time.
// A watchdog completes any transaction that the slave never acknowledges.
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   m_mem_valid/instr  per-master request and instruction-fetch flag
//   m_mem_addr/wdata   master i at [32*i +: 32]
//   m_mem_wstrb        master i at [4*i +: 4]; 0 = read
//   m_mem_ready        one-cycle completion pulse to the granted master
//   m_mem_rdata        shared read data; non-zero only during the ready pulse
//   s_mem_*            registered request toward the boot-ROM slave
//   grant_idx          current or most recently granted master
//   timeout_irq        one-cycle pulse when the watchdog forces a completion
module brom_bus_arbiter
  import brom_bus_arbiter_pkg::*;
#(
  parameter  int          NUM_MASTERS    = 2,
  parameter  int          TIMEOUT_CYCLES = 256,
  parameter  logic [31:0] TIMEOUT_RDATA  = DEF_TIMEOUT_RDATA,
  localparam int          IDX_W          = $clog2(NUM_MASTERS)
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NUM_MASTERS-1:0]    m_mem_valid,
  input  logic [NUM_MASTERS-1:0]    m_mem_instr,
  input  logic [32*NUM_MASTERS-1:0] m_mem_addr,
  input  logic [32*NUM_MASTERS-1:0] m_mem_wdata,
  input  logic [4*NUM_MASTERS-1:0]  m_mem_wstrb,
  output logic [NUM_MASTERS-1:0]    m_mem_ready,
  output logic [31:0]               m_mem_rdata,
  output logic                      s_mem_valid,
  output logic                      s_mem_instr,
  output logic [31:0]               s_mem_addr,
  output logic [31:0]               s_mem_wdata,
  output logic [3:0]                s_mem_wstrb,
  input  logic                      s_mem_ready,
  input  logic [31:0]               s_mem_rdata,
  output logic [IDX_W-1:0]          grant_idx,
  output logic                      timeout_irq
);

  localparam int                WD_W     = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WD_W-1:0]   WD_TC    = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_MASTERS - 1);

  state_e                   state_q,   state_d;
  logic [IDX_W-1:0]         rr_ptr_q,  rr_ptr_d;
  logic [WD_W-1:0]          wd_q,      wd_d;
  logic [IDX_W-1:0]         grant_q,   grant_d;
  logic                     s_valid_q, s_valid_d;
  logic                     s_instr_q, s_instr_d;
  logic [31:0]              s_addr_q,  s_addr_d;
  logic [31:0]              s_wdata_q, s_wdata_d;
  logic [3:0]               s_wstrb_q, s_wstrb_d;
  logic [NUM_MASTERS-1:0]   ready_q,   ready_d;
  logic [31:0]              rdata_q,   rdata_d;
  logic                     irq_q,     irq_d;

  logic [NUM_MASTERS-1:0]   gnt_oh;
  logic [IDX_W-1:0]         gnt_idx;
  logic                     gnt_any;
  logic                     sel_instr;
  logic [31:0]              sel_addr;
  logic [31:0]              sel_wdata;
  logic [3:0]               sel_wstrb;

  rr_arbiter #(.N(NUM_MASTERS)) u_rr (
    .req        (m_mem_valid),
    .ptr        (rr_ptr_q),
    .gnt_onehot (gnt_oh),
    .gnt_idx    (gnt_idx),
    .gnt_any    (gnt_any)
  );

  // Request mux. Only the granted master's fields pass; the others are never sampled.
  always_comb begin
    sel_instr = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (gnt_oh[i]) begin
        sel_instr = m_mem_instr[i];
        sel_addr  = m_mem_addr[32*i +: 32];
        sel_wdata = m_mem_wdata[32*i +: 32];
        sel_wstrb = m_mem_wstrb[4*i +: 4];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    wd_d      = wd_q;
    grant_d   = grant_q;
    s_valid_d = s_valid_q;
    s_instr_d = s_instr_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    s_wstrb_d = s_wstrb_q;
    ready_d   = '0;
    rdata_d   = '0;
    irq_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        wd_d = '0;
        if (gnt_any) begin
          grant_d   = gnt_idx;
          s_instr_d = sel_instr;
          s_addr_d  = sel_addr;
          s_wdata_d = sel_wdata;
          s_wstrb_d = sel_wstrb;
          s_valid_d = 1'b1;
          state_d   = ST_BUSY;
        end
      end

      ST_BUSY: begin
        if (wd_q != '1) wd_d = wd_q + 1'b1;
        // A slave ready in the terminal watchdog cycle still counts as a normal completion.
        if (s_mem_ready || (wd_q == WD_TC)) begin
          ready_d[grant_q] = 1'b1;
          s_valid_d        = 1'b0;
          state_d          = ST_DONE;
          if (s_mem_ready) begin
            rdata_d = s_mem_rdata;
          end else begin
            rdata_d = TIMEOUT_RDATA;
            irq_d   = 1'b1;
          end
        end
      end

      ST_DONE: begin
        // Bubble cycle lets the served master drop valid before re-arbitration.
        rr_ptr_d = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
        wd_d     = '0;
        state_d  = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      wd_q      <= '0;
      grant_q   <= '0;
      s_valid_q <= 1'b0;
      s_instr_q <= 1'b0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      s_wstrb_q <= '0;
      ready_q   <= '0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      wd_q      <= wd_d;
      grant_q   <= grant_d;
      s_valid_q <= s_valid_d;
      s_instr_q <= s_instr_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      s_wstrb_q <= s_wstrb_d;
      ready_q   <= ready_d;
      rdata_q   <= rdata_d;
      irq_q     <= irq_d;
    end
  end

  assign m_mem_ready = ready_q;
  assign m_mem_rdata = rdata_q;
  assign s_mem_valid = s_valid_q;
  assign s_mem_instr = s_instr_q;
  assign s_mem_addr  = s_addr_q;
  assign s_mem_wdata = s_wdata_q;
  assign s_mem_wstrb = s_wstrb_q;
  assign grant_idx   = grant_q;
  assign timeout_irq = irq_q;

endmodule

// File: tb/tb_brom_bus_arbiter.sv
module tb_brom_bus_arbiter;

  localparam int NM = 2;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          resetn;
  logic [1:0]    m_mem_valid;
  logic [1:0]    m_mem_instr;
  logic [63:0]   m_mem_addr;
  logic [63:0]   m_mem_wdata;
  logic [7:0]    m_mem_wstrb;
  logic [1:0]    m_mem_ready;
  logic [31:0]   m_mem_rdata;
  logic          s_mem_valid;
  logic          s_mem_instr;
  logic [31:0]   s_mem_addr;
  logic [31:0]   s_mem_wdata;
  logic [3:0]    s_mem_wstrb;
  logic          s_mem_ready;
  logic [31:0]   s_mem_rdata;
  logic          grant_idx;
  logic          timeout_irq;

  int n_vec = 0;
  int n_err = 0;

  // Reference copy of what each master presents.
  logic [31:0] ref_addr  [NM];
  logic [31:0] ref_wdata [NM];
  logic [3:0]  ref_wstrb [NM];
  logic        ref_instr [NM];
  int          model_ptr = 0;

  always #5 clk = ~clk;

  brom_bus_arbiter #(.NUM_MASTERS(NM), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .m_mem_valid (m_mem_valid),
    .m_mem_instr (m_mem_instr),
    .m_mem_addr  (m_mem_addr),
    .m_mem_wdata (m_mem_wdata),
    .m_mem_wstrb (m_mem_wstrb),
    .m_mem_ready (m_mem_ready),
    .m_mem_rdata (m_mem_rdata),
    .s_mem_valid (s_mem_valid),
    .s_mem_instr (s_mem_instr),
    .s_mem_addr  (s_mem_addr),
    .s_mem_wdata (s_mem_wdata),
    .s_mem_wstrb (s_mem_wstrb),
    .s_mem_ready (s_mem_ready),
    .s_mem_rdata (s_mem_rdata),
    .grant_idx   (grant_idx),
    .timeout_irq (timeout_irq)
  );

  function automatic logic [105:0] all_outs();
    return {m_mem_ready, m_mem_rdata, s_mem_valid, s_mem_instr, s_mem_addr,
            s_mem_wdata, s_mem_wstrb, grant_idx, timeout_irq};
  endfunction

  // Round-robin rule: first requesting master at or after the pointer, wrapping.
  function automatic int pick(input logic [1:0] vmask, input int ptr);
    for (int j = 0; j < NM; j++) begin
      if (vmask[(ptr + j) % NM]) return (ptr + j) % NM;
    end
    return -1;
  endfunction

  task automatic set_master(input int i, input logic instr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] wstrb);
    ref_instr[i] = instr;
    ref_addr[i]  = addr;
    ref_wdata[i] = wdata;
    ref_wstrb[i] = wstrb;
    m_mem_instr[i]          = instr;
    m_mem_addr[32*i +: 32]  = addr;
    m_mem_wdata[32*i +: 32] = wdata;
    m_mem_wstrb[4*i +: 4]   = wstrb;
  endtask

  // Drives one transaction from an IDLE negedge; the slave raises ready in BUSY cycle k.
  // Returns what was observed and ends on the negedge of the ready-pulse cycle.
  task automatic do_txn(input logic [1:0] vmask, input int k, input logic [31:0] srd,
                        output int lat, output int busy_n, output logic g_seen,
                        output logic [68:0] req_seen, output bit stable, output bit quiet,
                        output logic [1:0] rdy, output logic [31:0] rdata,
                        output logic irq, output bit hung);
    lat = 0; busy_n = 0; g_seen = 1'bx; req_seen = 'x;
    stable = 1'b1; quiet = 1'b1; hung = 1'b0;
    rdy = 'x; rdata = 'x; irq = 1'bx;
    m_mem_valid = vmask;
    s_mem_ready = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (m_mem_ready !== 2'b00) quiet = 1'b0;
    end while (s_mem_valid !== 1'b1 && lat < 8);
    if (s_mem_valid !== 1'b1) begin
      hung = 1'b1;
      return;
    end
    g_seen   = grant_idx;
    req_seen = {s_mem_instr, s_mem_addr, s_mem_wdata, s_mem_wstrb};
    if (m_mem_rdata !== 32'h0 || timeout_irq !== 1'b0) quiet = 1'b0;
    busy_n = 1;
    while (1) begin
      s_mem_ready = (busy_n == k);
      s_mem_rdata = (busy_n == k) ? srd : $urandom;
      @(negedge clk);
      if (m_mem_ready !== 2'b00 || s_mem_valid !== 1'b1) break;
      busy_n++;
      if ({s_mem_instr, s_mem_addr, s_mem_wdata, s_mem_wstrb} !== req_seen) stable = 1'b0;
      if (m_mem_rdata !== 32'h0 || timeout_irq !== 1'b0) quiet = 1'b0;
      if (busy_n > 40) begin
        hung = 1'b1;
        break;
      end
    end
    s_mem_ready = 1'b0;
    rdy   = m_mem_ready;
    rdata = m_mem_rdata;
    irq   = timeout_irq;
  endtask

  // Drops all valids during DONE (with a stray slave ready) and returns the IDLE-cycle outputs.
  task automatic idle_gap(output logic [35:0] obs);
    m_mem_valid = 2'b00;
    s_mem_ready = 1'($urandom_range(0, 1));
    s_mem_rdata = $urandom;
    @(negedge clk);
    obs = {m_mem_ready, timeout_irq, s_mem_valid, m_mem_rdata};
    s_mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (all_outs() !== 106'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want 0", all_outs());
    end
    resetn = 1'b1;
    model_ptr = 0;
    @(negedge clk);
    n_vec++;
    if (all_outs() !== 106'h0) begin
      n_err++;
      $display("FAIL reset_release_idle: got %h want 0", all_outs());
    end
  endtask

  task automatic test_single_read();
    int lat, bn; logic g; logic [68:0] rq; bit st, qt, hg;
    logic [1:0] rdy; logic [31:0] rd; logic irq; logic [35:0] obs;
    set_master(0, 1'b0, 32'h8000_0000, 32'h0, 4'h0);
    do_txn(2'b01, 2, 32'h1234_5678, lat, bn, g, rq, st, qt, rdy, rd, irq, hg);
    n_vec++;
    if (hg !== 1'b0 || lat + bn !== 3) begin
      n_err++;
      $display("FAIL single_latency: got %0d cycles (hung=%0d) want 3", lat + bn, hg);
    end
    n_vec++;
    if ({g, rq} !== {1'b0, 1'b0, 32'h8000_0000, 32'h0, 4'h0}) begin
      n_err++;
      $display("FAIL single_request: got %h want grant 0 addr 80000000", {g, rq});
    end
    n_vec++;
    if ({rdy, rd, irq} !== {2'b01, 32'h1234_5678, 1'b0}) begin
      n_err++;
      $display("FAIL single_response: got rdy %b rdata %h irq %b want 01 12345678 0", rdy, rd, irq);
    end
    n_vec++;
    if ({st, qt} !== 2'b11) begin
      n_err++;
      $display("FAIL single_stable_quiet: got %b want 11", {st, qt});
    end
    model_ptr = 1;
    idle_gap(obs);
    n_vec++;
    if (obs !== 36'h0) begin
      n_err++;
      $display("FAIL single_after_pulse: got %h want 0", obs);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bn, w, prev; logic g; logic [68:0] rq; bit st, qt, hg;
    logic [1:0] rdy; logic [31:0] rd, srd; logic irq; logic [35:0] obs;
    set_master(0, 1'b0, 32'h8000_0100, 32'h0, 4'h0);
    set_master(1, 1'b0, 32'h8000_0200, 32'h0, 4'h0);
    prev = -1;
    for (int t = 0; t < 4; t++) begin
      w   = pick(2'b11, model_ptr);
      srd = $urandom;
      do_txn(2'b11, 2, srd, lat, bn, g, rq, st, qt, rdy, rd, irq, hg);
      n_vec++;
      if (hg !== 1'b0 || rdy !== 2'(1 << w) || int'(g) !== w || w == prev) begin
        n_err++;
        $display("FAIL b2b_grant[%0d]: got rdy %b grant %0d want master %0d", t, rdy, g, w);
      end
      n_vec++;
      if (lat + bn !== ((t == 0) ? 3 : 4) || rd !== srd || rq[67:36] !== ref_addr[w]) begin
        n_err++;
        $display("FAIL b2b_timing[%0d]: got %0d cycles rdata %h addr %h want %0d %h %h",
                 t, lat + bn, rd, rq[67:36], (t == 0) ? 3 : 4, srd, ref_addr[w]);
      end
      prev = w;
      model_ptr = (w + 1) % NM;
    end
    idle_gap(obs);
  endtask

  task automatic test_timeout();
    int lat, bn; logic g; logic [68:0] rq; bit st, qt, hg;
    logic [1:0] rdy; logic [31:0] rd; logic irq; logic [35:0] obs;
    set_master(1, 1'b1, 32'h8000_0040, 32'h0, 4'h0);
    do_txn(2'b10, 1000, 32'h5555_AAAA, lat, bn, g, rq, st, qt, rdy, rd, irq, hg);
    n_vec++;
    if (hg !== 1'b0 || bn !== TO || lat !== 1) begin
      n_err++;
      $display("FAIL timeout_cycles: got %0d busy (hung=%0d) want %0d", bn, hg, TO);
    end
    n_vec++;
    if ({rdy, rd, irq, rq[68]} !== {2'b10, 32'hDEAD_BEEF, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL timeout_response: got rdy %b rdata %h irq %b instr %b want 10 deadbeef 1 1",
               rdy, rd, irq, rq[68]);
    end
    n_vec++;
    if ({st, qt} !== 2'b11) begin
      n_err++;
      $display("FAIL timeout_stable_quiet: got %b want 11", {st, qt});
    end
    model_ptr = 0;
    idle_gap(obs);
    n_vec++;
    if (obs !== 36'h0) begin
      n_err++;
      $display("FAIL timeout_irq_single: got %h want 0", obs);
    end
  endtask

  task automatic test_timeout_coincident();
    int lat, bn; logic g; logic [68:0] rq; bit st, qt, hg;
    logic [1:0] rdy; logic [31:0] rd; logic irq; logic [35:0] obs;
    set_master(0, 1'b0, 32'h8000_0080, 32'h0, 4'h0);
    do_txn(2'b01, TO, 32'hC0DE_0016, lat, bn, g, rq, st, qt, rdy, rd, irq, hg);
    n_vec++;
    if ({hg, bn[7:0], rdy, rd, irq} !== {1'b0, 8'(TO), 2'b01, 32'hC0DE_0016, 1'b0}) begin
      n_err++;
      $display("FAIL coincident: got busy %0d rdy %b rdata %h irq %b want %0d 01 c0de0016 0",
               bn, rdy, rd, irq, TO);
    end
    model_ptr = 1;
    idle_gap(obs);
  endtask

  task automatic test_write();
    int lat, bn; logic g; logic [68:0] rq; bit st, qt, hg;
    logic [1:0] rdy; logic [31:0] rd; logic irq; logic [35:0] obs;
    set_master(1, 1'b0, 32'h8000_0010, 32'hAABB_CCDD, 4'b0011);
    do_txn(2'b10, 5, 32'h0, lat, bn, g, rq, st, qt, rdy, rd, irq, hg);
    n_vec++;
    if ({hg, g, rq} !== {1'b0, 1'b1, 1'b0, 32'h8000_0010, 32'hAABB_CCDD, 4'b0011}) begin
      n_err++;
      $display("FAIL write_request: got %h want grant 1 80000010 aabbccdd 3", rq);
    end
    n_vec++;
    if ({st, qt, rdy, bn[7:0]} !== {1'b1, 1'b1, 2'b10, 8'd5}) begin
      n_err++;
      $display("FAIL write_complete: got stable %b quiet %b rdy %b busy %0d want 1 1 10 5",
               st, qt, rdy, bn);
    end
    model_ptr = 0;
    idle_gap(obs);
    n_vec++;
    if (obs[35:34] !== 2'b00) begin
      n_err++;
      $display("FAIL write_ready_once: got %b want 00", obs[35:34]);
    end
  endtask

  task automatic test_reset_mid_busy();
    int lat, bn, n; logic g; logic [68:0] rq; bit st, qt, hg;
    logic [1:0] rdy; logic [31:0] rd; logic irq; logic [35:0] obs;
    set_master(0, 1'b0, 32'h8000_0000, 32'h0, 4'h0);
    set_master(1, 1'b1, 32'h8000_0300, 32'h0, 4'h0);
    // Master 0 is served first so the pointer favours master 1 before the reset.
    do_txn(2'b01, 2, 32'h1, lat, bn, g, rq, st, qt, rdy, rd, irq, hg);
    idle_gap(obs);
    m_mem_valid = 2'b10;
    n = 0;
    while (s_mem_valid !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if ({s_mem_valid, grant_idx} !== 2'b11) begin
      n_err++;
      $display("FAIL rst_busy_setup: got valid %b grant %b want 1 1", s_mem_valid, grant_idx);
    end
    #2 resetn = 1'b0;
    #1;
    n_vec++;
    if (all_outs() !== 106'h0) begin
      n_err++;
      $display("FAIL rst_async_outputs: got %h want 0", all_outs());
    end
    m_mem_valid = 2'b00;
    @(negedge clk);
    resetn = 1'b1;
    model_ptr = 0;
    repeat (3) begin
      @(negedge clk);
      n_vec++;
      if ({m_mem_ready, timeout_irq, s_mem_valid} !== 4'b0) begin
        n_err++;
        $display("FAIL rst_no_stale: got ready %b irq %b valid %b want 0", m_mem_ready,
                 timeout_irq, s_mem_valid);
      end
    end
    do_txn(2'b11, 2, 32'h7777_0000, lat, bn, g, rq, st, qt, rdy, rd, irq, hg);
    n_vec++;
    if ({hg, g, rdy, rd, qt} !== {1'b0, 1'b0, 2'b01, 32'h7777_0000, 1'b1}) begin
      n_err++;
      $display("FAIL rst_first_grant: got grant %b rdy %b rdata %h want 0 01 77770000", g, rdy, rd);
    end
    model_ptr = 1;
    idle_gap(obs);
  endtask

  task automatic test_random();
    int lat, bn, w, k, exp_bn; logic g; logic [68:0] rq; bit st, qt, hg;
    logic [1:0] rdy, vm; logic [31:0] rd, srd, exp_rd; logic irq, exp_irq; logic [35:0] obs;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < NM; i++)
        set_master(i, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
      vm      = 2'($urandom_range(1, 3));
      k       = $urandom_range(1, TO + 6);
      srd     = $urandom;
      w       = pick(vm, model_ptr);
      exp_bn  = (k <= TO) ? k : TO;
      exp_rd  = (k <= TO) ? srd : 32'hDEAD_BEEF;
      exp_irq = (k > TO);
      do_txn(vm, k, srd, lat, bn, g, rq, st, qt, rdy, rd, irq, hg);
      n_vec++;
      if (hg !== 1'b0 || int'(g) !== w || rq !== {ref_instr[w], ref_addr[w], ref_wdata[w], ref_wstrb[w]}) begin
        n_err++;
        $display("FAIL rand_request[%0d]: got grant %b req %h want %0d %h", t, g, rq, w,
                 {ref_instr[w], ref_addr[w], ref_wdata[w], ref_wstrb[w]});
      end
      n_vec++;
      if ({rdy, rd, irq} !== {2'(1 << w), exp_rd, exp_irq} || bn !== exp_bn || lat !== 1) begin
        n_err++;
        $display("FAIL rand_response[%0d]: got rdy %b rdata %h irq %b busy %0d want %b %h %b %0d",
                 t, rdy, rd, irq, bn, 2'(1 << w), exp_rd, exp_irq, exp_bn);
      end
      n_vec++;
      if ({st, qt} !== 2'b11) begin
        n_err++;
        $display("FAIL rand_stable_quiet[%0d]: got %b want 11", t, {st, qt});
      end
      model_ptr = (w + 1) % NM;
      idle_gap(obs);
      n_vec++;
      if (obs !== 36'h0) begin
        n_err++;
        $display("FAIL rand_idle[%0d]: got %h want 0", t, obs);
      end
    end
  endtask

  initial begin
    resetn      = 1'b0;
    m_mem_valid = '0;
    m_mem_instr = '0;
    m_mem_addr  = '0;
    m_mem_wdata = '0;
    m_mem_wstrb = '0;
    s_mem_ready = 1'b0;
    s_mem_rdata = '0;
    test_reset();
    test_single_read();
    test_back_to_back();
    test_timeout();
    test_timeout_coincident();
    test_write();
    test_reset_mid_busy();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
